// File: rtl/cursor_overlay.sv
// Sprite cursor overlay for the VGA stream: draws one of NUM_SPRITES ROM sprites at the
// mouse position, with frame-latched parameters and a timing delay matched to the ROM latency.
module cursor_overlay #(
   parameter int          NUM_SPRITES = 2,
   parameter int          SPR_W       = 48,
   parameter int          SPR_H       = 48,
   parameter int          ROM_LAT     = 1,
   parameter logic [11:0] TRANSP      = 12'h0F0,
   parameter int          SEL_W       = 2,
   parameter int          ADDR_W      = $clog2(NUM_SPRITES*SPR_W*SPR_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [11:0]       xpos,
   input  logic [11:0]       ypos,
   input  logic [SEL_W-1:0]  sprite_sel,
   input  logic              ovl_en,
   input  logic [10:0]       in_hcount,
   input  logic [10:0]       in_vcount,
   input  logic              in_hsync,
   input  logic              in_vsync,
   input  logic              in_hblnk,
   input  logic              in_vblnk,
   input  logic [11:0]       in_rgb,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   output logic [10:0]       out_hcount,
   output logic [10:0]       out_vcount,
   output logic              out_hsync,
   output logic              out_vsync,
   output logic              out_hblnk,
   output logic              out_vblnk,
   output logic [11:0]       out_rgb,
   output logic              frame_tick
);

   localparam int L = ROM_LAT + 1;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } video_t;

   video_t             line_q [L];
   logic [ROM_LAT:0]   hit_q;
   logic               vsync_q;
   logic [11:0]        act_x;
   logic [11:0]        act_y;
   logic [SEL_W-1:0]   act_sel;
   logic               act_en;

   logic               vs_rise;
   logic signed [12:0] dx;
   logic signed [12:0] dy;
   logic               hit;
   logic [ADDR_W-1:0]  addr_next;

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      vs_rise   = in_vsync && !vsync_q;
      dx        = $signed({2'b00, in_hcount}) - $signed({1'b0, act_x});
      dy        = $signed({2'b00, in_vcount}) - $signed({1'b0, act_y});
      hit       = act_en && !in_hblnk && !in_vblnk
                  && !dx[12] && (int'(dx) < SPR_W)
                  && !dy[12] && (int'(dy) < SPR_H);
      addr_next = ADDR_W'(int'(act_sel) * SPR_W * SPR_H + int'(dy) * SPR_W + int'(dx));
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q    <= 1'b0;
         act_x      <= '0;
         act_y      <= '0;
         act_sel    <= '0;
         act_en     <= 1'b0;
         frame_tick <= 1'b0;
         rom_addr   <= '0;
         hit_q      <= '0;
         // NOTE: the delay line is cleared too, so a reset mid-frame blanks the output cleanly.
         for (int i = 0; i < L; i++) line_q[i] <= '0;
      end else begin
         vsync_q    <= in_vsync;
         frame_tick <= vs_rise;
         if (vs_rise) begin
            act_x  <= xpos;
            act_y  <= ypos;
            act_en <= ovl_en;
            // Out-of-range selections keep the last valid sprite.
            if (int'(sprite_sel) < NUM_SPRITES) act_sel <= sprite_sel;
         end
         if (hit) rom_addr <= addr_next;
         hit_q     <= {hit_q[ROM_LAT-1:0], hit};
         line_q[0] <= '{hcount: in_hcount, vcount: in_vcount, hsync: in_hsync,
                        vsync: in_vsync, hblnk: in_hblnk, vblnk: in_vblnk, rgb: in_rgb};
         for (int i = 1; i < L; i++) line_q[i] <= line_q[i-1];
      end
   end

   // The final mux sits on rom_data directly so the total latency stays at ROM_LAT+1.
   assign out_hcount = line_q[L-1].hcount;
   assign out_vcount = line_q[L-1].vcount;
   assign out_hsync  = line_q[L-1].hsync;
   assign out_vsync  = line_q[L-1].vsync;
   assign out_hblnk  = line_q[L-1].hblnk;
   assign out_vblnk  = line_q[L-1].vblnk;
   assign out_rgb    = (hit_q[ROM_LAT] && rom_data != TRANSP) ? rom_data : line_q[L-1].rgb;

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed bench for cursor_overlay: ROM_LAT=2 ramp ROM model, hand-computed expected pixels.
module tb_cursor_overlay;

   localparam int NUM_SPRITES = 2;
   localparam int SPR_W       = 48;
   localparam int SPR_H       = 48;
   localparam int ROM_LAT     = 2;
   localparam int L           = ROM_LAT + 1;
   localparam int ADDR_W      = $clog2(NUM_SPRITES*SPR_W*SPR_H);

   logic              clk = 1'b0;
   logic              rst;
   logic [11:0]       xpos, ypos;
   logic [1:0]        sprite_sel;
   logic              ovl_en;
   logic [10:0]       in_hcount, in_vcount;
   logic              in_hsync, in_vsync, in_hblnk, in_vblnk;
   logic [11:0]       in_rgb;
   logic [ADDR_W-1:0] rom_addr;
   logic [11:0]       rom_data;
   logic [10:0]       out_hcount, out_vcount;
   logic              out_hsync, out_vsync, out_hblnk, out_vblnk;
   logic [11:0]       out_rgb;
   logic              frame_tick;

   int n_pass   = 0;
   int n_checks = 0;

   always #5 clk = ~clk;

   cursor_overlay #(
      .NUM_SPRITES(NUM_SPRITES), .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_LAT(ROM_LAT),
      .TRANSP(12'h0F0), .SEL_W(2), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .sprite_sel(sprite_sel),
      .ovl_en(ovl_en), .in_hcount(in_hcount), .in_vcount(in_vcount),
      .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
      .in_rgb(in_rgb), .rom_addr(rom_addr), .rom_data(rom_data),
      .out_hcount(out_hcount), .out_vcount(out_vcount), .out_hsync(out_hsync),
      .out_vsync(out_vsync), .out_hblnk(out_hblnk), .out_vblnk(out_vblnk),
      .out_rgb(out_rgb), .frame_tick(frame_tick)
   );

   // Ramp ROM: pixel = low 12 address bits, except sprite 1 pixel (3,3) is the colour key.
   function automatic logic [11:0] rom_model(input logic [ADDR_W-1:0] a);
      if (a == ADDR_W'(2451)) return 12'h0F0;
      return a[11:0];
   endfunction

   logic [11:0] rom_pipe [ROM_LAT];
   always @(posedge clk) begin
      rom_pipe[0] <= rom_model(rom_addr);
      for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign rom_data = rom_pipe[ROM_LAT-1];

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   // Drive one pixel, hold it for L cycles, then compare the overlaid colour.
   task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v,
                        input logic [11:0] bg, input logic [11:0] exp_rgb);
      in_hcount = h;
      in_vcount = v;
      in_rgb    = bg;
      repeat (L) @(posedge clk);
      @(negedge clk);
      check(tag, {20'd0, out_rgb}, {20'd0, exp_rgb});
   endtask

   task automatic vsync_pulse(input string tag);
      in_vsync = 1'b1;
      in_vblnk = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_tick_hi"}, {31'd0, frame_tick}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_tick_lo"}, {31'd0, frame_tick}, 32'd0);
      in_vsync = 1'b0;
      in_vblnk = 1'b0;
   endtask

   initial begin
      // Reset with random inputs
      rst        = 1'b1;
      xpos       = 12'($urandom);
      ypos       = 12'($urandom);
      sprite_sel = 2'($urandom);
      ovl_en     = 1'($urandom);
      in_hcount  = 11'($urandom);
      in_vcount  = 11'($urandom);
      in_hsync   = 1'b1;
      in_vsync   = 1'($urandom);
      in_hblnk   = 1'($urandom);
      in_vblnk   = 1'($urandom);
      in_rgb     = 12'($urandom);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("reset_video", {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk},
            32'd0);
      check("reset_rgb", {20'd0, out_rgb}, 32'd0);
      check("reset_addr", {19'd0, rom_addr}, 32'd0);
      check("reset_tick", {31'd0, frame_tick}, 32'd0);

      // Release with overlay requested but no vsync edge yet: pass-through
      xpos = 12'd0; ypos = 12'd0; sprite_sel = 2'd1; ovl_en = 1'b1;
      in_hsync = 1'b0; in_vsync = 1'b0; in_hblnk = 1'b0; in_vblnk = 1'b0;
      rst = 1'b0;
      probe("pass_no_latch", 11'd10, 11'd10, 12'hABC, 12'hABC);

      // Exact latency of L cycles on rgb and timing flags
      in_rgb    = 12'h5A5;
      in_hsync  = 1'b1;
      in_hcount = 11'd11;
      repeat (L-1) @(posedge clk);
      @(negedge clk);
      check("lat_early_rgb", {20'd0, out_rgb}, 32'hABC);
      check("lat_early_hsync", {31'd0, out_hsync}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("lat_rgb", {20'd0, out_rgb}, 32'h5A5);
      check("lat_hsync", {31'd0, out_hsync}, 32'd1);
      check("lat_hcount", {21'd0, out_hcount}, 32'd11);
      check("pass_addr_static", {19'd0, rom_addr}, 32'd0);
      in_hsync = 1'b0;

      // Sprite 1 at (100,50)
      xpos = 12'd100; ypos = 12'd50; sprite_sel = 2'd1; ovl_en = 1'b1;
      vsync_pulse("f1");
      probe("s1_origin", 11'd100, 11'd50, 12'h333, 12'h900);
      check("s1_origin_addr", {19'd0, rom_addr}, 32'd2304);
      probe("s1_last_col", 11'd147, 11'd50, 12'h333, 12'h92F);
      probe("s1_right_edge", 11'd148, 11'd50, 12'h333, 12'h333);
      probe("s1_left_edge", 11'd99, 11'd50, 12'h333, 12'h333);
      probe("s1_last_row", 11'd100, 11'd97, 12'h333, 12'h1D0);
      probe("s1_below", 11'd100, 11'd98, 12'h333, 12'h333);
      probe("s1_transp", 11'd103, 11'd53, 12'h333, 12'h333);
      probe("s1_transp_nbr", 11'd104, 11'd53, 12'h333, 12'h994);
      in_hblnk = 1'b1;
      probe("s1_hblnk", 11'd100, 11'd50, 12'h333, 12'h333);
      in_hblnk = 1'b0;

      // Select changes mid-frame: no effect until the next latch
      sprite_sel = 2'd0;
      probe("sel_mid_v300", 11'd100, 11'd300, 12'h222, 12'h222);
      probe("sel_mid_still1", 11'd110, 11'd60, 12'h222, 12'hAEA);
      vsync_pulse("f2");
      probe("sel_new0", 11'd110, 11'd60, 12'h222, 12'h1EA);

      // Right-edge clipping, no wrap
      xpos = 12'd1000; ypos = 12'd50; sprite_sel = 2'd1;
      vsync_pulse("f3");
      probe("clip_first", 11'd1000, 11'd50, 12'h555, 12'h900);
      probe("clip_col23", 11'd1023, 11'd50, 12'h555, 12'h917);
      check("clip_col23_addr", {19'd0, rom_addr}, 32'd2327);
      probe("clip_dx_neg", 11'd999, 11'd50, 12'h555, 12'h555);
      probe("nowrap_h0", 11'd0, 11'd50, 12'h555, 12'h555);
      probe("nowrap_h23", 11'd23, 11'd50, 12'h555, 12'h555);
      check("miss_addr_hold", {19'd0, rom_addr}, 32'd2327);

      // Out-of-range select keeps the previous sprite
      xpos = 12'd100; ypos = 12'd50; sprite_sel = 2'd3;
      vsync_pulse("f4");
      probe("sel3_retained", 11'd100, 11'd50, 12'h666, 12'h900);

      // Overlay disabled for the whole frame
      ovl_en = 1'b0; sprite_sel = 2'd0;
      vsync_pulse("f5");
      probe("off_origin", 11'd100, 11'd50, 12'h444, 12'h444);
      probe("off_inside", 11'd110, 11'd60, 12'h444, 12'h444);
      check("off_addr_static", {19'd0, rom_addr}, 32'd2304);

      // Reset mid-frame turns the overlay off until the next vsync edge
      ovl_en = 1'b1; sprite_sel = 2'd1;
      vsync_pulse("f6");
      probe("pre_rst_on", 11'd100, 11'd50, 12'h777, 12'h900);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      probe("post_rst_off", 11'd100, 11'd50, 12'h777, 12'h777);
      check("post_rst_tick", {31'd0, frame_tick}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
